// File: rtl/key_load_ctrl_pkg.sv
// Shared definitions for the key loader: default frame geometry and the FSM state type.
package key_load_ctrl_pkg;

   localparam int KEY_BYTES_DEF = 16;
   localparam int BYTE_W_DEF    = 8;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      HOLD,
      LOAD,
      READY
   } state_e;

endpackage

// File: rtl/key_load_ctrl_byte_counter.sv
// Saturating byte counter next-value logic; the owning FSM holds the actual count/overflow flops.
module key_load_ctrl_byte_counter
   import key_load_ctrl_pkg::*;
#(
   parameter int KEY_BYTES = KEY_BYTES_DEF,
   parameter int CNT_W     = $clog2(KEY_BYTES + 1)
) (
   input  logic [CNT_W-1:0] cnt_in,
   input  logic             ovf_in,
   input  logic             byte_valid,
   output logic [CNT_W-1:0] cnt_out,
   output logic             ovf_out,
   output logic             accept
);

   logic full;

   assign full = (cnt_in == CNT_W'(KEY_BYTES));

   // A byte beyond a full frame is refused and only marks the frame as overlong.
   assign accept  = byte_valid & ~full;
   assign cnt_out = accept ? cnt_in + CNT_W'(1) : cnt_in;
   assign ovf_out = ovf_in | (byte_valid & full);

endmodule

// File: rtl/key_load_ctrl.sv
// Assembles a KEY_BYTES-byte key frame from a serial bus and strobes it into the key register
// only when the frame was exactly the right length and the encryptor is idle.
module key_load_ctrl
   import key_load_ctrl_pkg::*;
#(
   parameter int KEY_BYTES = KEY_BYTES_DEF,
   parameter int BYTE_W    = BYTE_W_DEF
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic                          start_det,
   input  logic                          stop_det,
   input  logic                          byte_valid,
   input  logic [BYTE_W-1:0]             byte_in,
   input  logic                          aes_busy,
   input  logic                          key_consumed,
   output logic [KEY_BYTES*BYTE_W-1:0]   rx_data,
   output logic                          reg_enable,
   output logic                          key_valid,
   output logic                          frame_err
);

   localparam int KEY_W = KEY_BYTES * BYTE_W;
   localparam int CNT_W = $clog2(KEY_BYTES + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [KEY_W-1:0]   buf_q, buf_d;
   logic               ovf_q, ovf_d, ovf_inc, byte_accept;
   logic               reg_enable_q, reg_enable_d;
   logic               key_valid_q, key_valid_d;
   logic               frame_err_q, frame_err_d;

   key_load_ctrl_byte_counter #(
      .KEY_BYTES (KEY_BYTES),
      .CNT_W     (CNT_W)
   ) u_byte_counter (
      .cnt_in     (cnt_q),
      .ovf_in     (ovf_q),
      .byte_valid (byte_valid),
      .cnt_out    (cnt_inc),
      .ovf_out    (ovf_inc),
      .accept     (byte_accept)
   );

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      state_d      = state_q;
      cnt_d        = cnt_q;
      buf_d        = buf_q;
      ovf_d        = ovf_q;
      reg_enable_d = 1'b0;
      key_valid_d  = key_valid_q & ~key_consumed;
      frame_err_d  = frame_err_q;

      case (state_q)
         IDLE: begin
            if (start_det) begin
               state_d = COLLECT;
               cnt_d   = '0;
               buf_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         COLLECT: begin
            if (start_det) begin
               cnt_d = '0;
               buf_d = '0;
               ovf_d = 1'b0;
            end else begin
               // A byte arriving with the stop is folded in before the stop is judged.
               cnt_d = cnt_inc;
               ovf_d = ovf_inc;
               if (byte_accept) buf_d = {buf_q[KEY_W-BYTE_W-1:0], byte_in};
               if (stop_det) begin
                  if (cnt_inc == CNT_W'(KEY_BYTES) && !ovf_inc) begin
                     if (aes_busy) begin
                        state_d = HOLD;
                     end else begin
                        state_d      = LOAD;
                        reg_enable_d = 1'b1;
                        frame_err_d  = 1'b0;
                     end
                  end else begin
                     state_d     = IDLE;
                     frame_err_d = 1'b1;
                     cnt_d       = '0;
                     buf_d       = '0;
                     ovf_d       = 1'b0;
                  end
               end
            end
         end
         HOLD: begin
            if (!aes_busy) begin
               state_d      = LOAD;
               reg_enable_d = 1'b1;
               frame_err_d  = 1'b0;
            end
         end
         LOAD: begin
            // If the encryptor woke up during the strobe, the gated strobe was suppressed: retry.
            if (aes_busy) begin
               state_d = HOLD;
            end else begin
               state_d     = READY;
               key_valid_d = 1'b1;
            end
         end
         READY: begin
            if (start_det) begin
               state_d = COLLECT;
               cnt_d   = '0;
               buf_d   = '0;
               ovf_d   = 1'b0;
            end else if (key_consumed) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         buf_q        <= '0;
         ovf_q        <= 1'b0;
         reg_enable_q <= 1'b0;
         key_valid_q  <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         buf_q        <= buf_d;
         ovf_q        <= ovf_d;
         reg_enable_q <= reg_enable_d;
         key_valid_q  <= key_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign rx_data    = buf_q;
   assign reg_enable = reg_enable_q & ~aes_busy;
   assign key_valid  = key_valid_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_key_load_ctrl.sv
// Self-checking bench for key_load_ctrl: every load strobe is matched against a queue of expected keys.
module tb_key_load_ctrl;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         start_det, stop_det, byte_valid, aes_busy, key_consumed;
   logic [7:0]   byte_in;
   logic [127:0] rx_data;
   logic         reg_enable, key_valid, frame_err;

   int           n_checks = 0;
   int           n_fails  = 0;
   logic [127:0] sb[$];
   logic         prev_en = 1'b0;

   key_load_ctrl #(
      .KEY_BYTES (16),
      .BYTE_W    (8)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .start_det    (start_det),
      .stop_det     (stop_det),
      .byte_valid   (byte_valid),
      .byte_in      (byte_in),
      .aes_busy     (aes_busy),
      .key_consumed (key_consumed),
      .rx_data      (rx_data),
      .reg_enable   (reg_enable),
      .key_valid    (key_valid),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Scoreboard side: each strobe must be one cycle wide, outside busy, and carry the next queued key.
   always @(negedge clk) begin
      if (reg_enable === 1'b1) begin
         check("strobe_width", 128'(prev_en), 128'd0);
         check("busy_at_load", 128'(aes_busy), 128'd0);
         if (sb.size() == 0) check("unexpected_load", 128'(reg_enable), 128'd0);
         else                check("load_data", rx_data, sb.pop_front());
      end
      prev_en = reg_enable;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_start();
      start_det = 1'b1;
      tick();
      start_det = 1'b0;
   endtask

   task automatic send_stop();
      stop_det = 1'b1;
      tick();
      stop_det = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_in    = b;
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic send_bytes(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) send_byte(first + 8'(i));
   endtask

   task automatic consume();
      key_consumed = 1'b1;
      tick();
      key_consumed = 1'b0;
   endtask

   initial begin
      n_rst        = 1'b0;
      start_det    = 1'b0;
      stop_det     = 1'b0;
      byte_valid   = 1'b0;
      byte_in      = 8'h00;
      aes_busy     = 1'b0;
      key_consumed = 1'b0;
      #1;
      check("rst_rx_data", rx_data, 128'd0);
      check("rst_reg_enable", 128'(reg_enable), 128'd0);
      check("rst_key_valid", 128'(key_valid), 128'd0);
      check("rst_frame_err", 128'(frame_err), 128'd0);
      repeat (2) tick();
      n_rst = 1'b1;
      tick();

      // Good frame, encryptor idle: strobe one cycle after stop.
      sb.push_back(128'h000102030405060708090A0B0C0D0E0F);
      send_start();
      send_bytes(8'h00, 16);
      send_stop();
      check("good_latency", 128'(reg_enable), 128'd1);
      tick();
      check("good_strobe_end", 128'(reg_enable), 128'd0);
      check("good_key_valid", 128'(key_valid), 128'd1);
      check("good_frame_err", 128'(frame_err), 128'd0);
      consume();
      check("consumed_key_valid", 128'(key_valid), 128'd0);

      // Short frame.
      send_start();
      send_bytes(8'h40, 15);
      send_stop();
      check("short_frame_err", 128'(frame_err), 128'd1);
      check("short_reg_enable", 128'(reg_enable), 128'd0);
      check("short_discard", rx_data, 128'd0);

      // Overlong frame: 17th byte must not disturb the buffer.
      send_start();
      send_bytes(8'h10, 16);
      send_byte(8'hFF);
      check("overlong_buffer", rx_data, 128'h101112131415161718191A1B1C1D1E1F);
      send_stop();
      check("overlong_frame_err", 128'(frame_err), 128'd1);
      check("overlong_reg_enable", 128'(reg_enable), 128'd0);

      // Busy hold: start alone keeps frame_err; a start during HOLD is ignored.
      sb.push_back(128'h202122232425262728292A2B2C2D2E2F);
      aes_busy = 1'b1;
      send_start();
      check("start_keeps_err", 128'(frame_err), 128'd1);
      send_bytes(8'h20, 16);
      send_stop();
      for (int i = 0; i < 20; i++) begin
         if (i == 5) start_det = 1'b1;
         tick();
         start_det = 1'b0;
         check("hold_no_strobe", 128'(reg_enable), 128'd0);
      end
      aes_busy = 1'b0;
      tick();
      check("hold_release_strobe", 128'(reg_enable), 128'd1);
      check("load_clears_err", 128'(frame_err), 128'd0);
      tick();
      check("hold_key_valid", 128'(key_valid), 128'd1);
      consume();

      // Repeated START mid-frame restarts collection.
      send_start();
      send_bytes(8'h60, 3);
      send_stop();
      check("pre_restart_err", 128'(frame_err), 128'd1);
      sb.push_back(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
      send_start();
      send_bytes(8'h50, 5);
      send_start();
      send_bytes(8'hA0, 16);
      send_stop();
      check("restart_strobe", 128'(reg_enable), 128'd1);
      check("restart_frame_err", 128'(frame_err), 128'd0);
      tick();
      check("restart_key_valid", 128'(key_valid), 128'd1);

      // New frame from READY keeps key_valid; reset mid-frame clears everything at once.
      send_start();
      check("ready_start_key_valid", 128'(key_valid), 128'd1);
      send_bytes(8'h30, 8);
      check("mid_frame_data", rx_data, 128'h3031323334353637);
      n_rst = 1'b0;
      #1;
      check("arst_rx_data", rx_data, 128'd0);
      check("arst_reg_enable", 128'(reg_enable), 128'd0);
      check("arst_key_valid", 128'(key_valid), 128'd0);
      check("arst_frame_err", 128'(frame_err), 128'd0);
      repeat (2) tick();
      n_rst = 1'b1;
      tick();
      send_bytes(8'h38, 8);
      send_stop();
      for (int i = 0; i < 3; i++) begin
         check("post_reset_no_strobe", 128'(reg_enable), 128'd0);
         tick();
      end
      check("post_reset_frame_err", 128'(frame_err), 128'd0);
      check("post_reset_rx_data", rx_data, 128'd0);

      repeat (2) tick();
      check("sb_empty", 128'(sb.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
